load_store_unit: RTL and testbench

Memory-stage block that consumes the effective address and store operand produced by the execution stage for load/store instructions. It drives the data-memory request/acknowledge interface and handles byte-lane alignment, write strobes, load sign/zero extension and misalignment detection. It returns a one-cycle completion pulse with write-back data. It holds `busy` while a transaction is outstanding so the pipeline stalls.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/load_align.sv | 21 ++
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: instruction ids, FSM encoding and access-width helpers for the load/store unit
package mem_pkg;

    localparam logic [5:0] ID_LB  = 6'h14;
    localparam logic [5:0] ID_LH  = 6'h15;
    localparam logic [5:0] ID_LW  = 6'h16;
    localparam logic [5:0] ID_LBU = 6'h17;
    localparam logic [5:0] ID_LHU = 6'h18;
    localparam logic [5:0] ID_SB  = 6'h19;
    localparam logic [5:0] ID_SH  = 6'h1A;
    localparam logic [5:0] ID_SW  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_FIN  = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        W_BYTE = 2'd0,
        W_HALF = 2'd1,
        W_WORD = 2'd2,
        W_NONE = 2'd3
    } width_e;

    // W_NONE doubles as the "not a memory instruction" marker
    function automatic width_e access_width(input logic [5:0] id);
        return (id == ID_LB || id == ID_LBU || id == ID_SB) ? W_BYTE :
               (id == ID_LH || id == ID_LHU || id == ID_SH) ? W_HALF :
               (id == ID_LW || id == ID_SW)                 ? W_WORD : W_NONE;
    endfunction

    function automatic logic is_store(input logic [5:0] id);
        return id == ID_SB || id == ID_SH || id == ID_SW;
    endfunction

    function automatic logic is_aligned(input width_e w, input logic [1:0] lo);
        return w == W_WORD ? lo == 2'b00 : w == W_HALF ? !lo[0] : 1'b1;
    endfunction

endpackage

// File: rtl/load_align.sv
// load_align: moves the addressed lane of the read word to bit 0 and extends it to 32 bits
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [5:0]  id_i,
    output logic [31:0] load_data_o
);

    logic [31:0] shifted;

    assign shifted = rdata_i >> {addr_lo_i, 3'b000};

    assign load_data_o = id_i == ID_LB  ? {{24{shifted[7]}}, shifted[7:0]}   :
                         id_i == ID_LH  ? {{16{shifted[15]}}, shifted[15:0]} :
                         id_i == ID_LBU ? {24'h0, shifted[7:0]}              :
                         id_i == ID_LHU ? {16'h0, shifted[15:0]}             :
                         id_i == ID_LW  ? shifted                            : 32'h0;

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: memory-stage FSM driving the data-memory req/ack bus with lane alignment
module load_store_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  instr_id,
    input  logic [31:0] mem_addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd_addr,
    output logic        busy,
    output logic        done,
    output logic        wb_en,
    output logic [4:0]  wb_rd_addr,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        bus_err,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata
);

    // wide enough that the all-ones saturation value is always at least TIMEOUT
    localparam int CW = $clog2(TIMEOUT + 2);

    state_e      state_q, state_d;
    logic [5:0]  id_q, id_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        done_q, done_d;
    logic        wb_en_q, wb_en_d;
    logic        mis_q, mis_d;
    logic        err_q, err_d;
    logic [31:0] ld_q, ld_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] wdata_q, wdata_d;

    width_e      in_w;
    logic        in_valid;
    logic        in_ok;
    logic        in_st;
    logic [3:0]  in_wstrb;
    logic [31:0] in_wdata;
    logic        timeout;
    logic        ld_op;
    logic [31:0] aligned_data;

    load_align u_align (
        .rdata_i     (dmem_rdata),
        .addr_lo_i   (lo_q),
        .id_i        (id_q),
        .load_data_o (aligned_data)
    );

    // decode the incoming request into lane strobes and replicated store data
    always_comb begin
        in_w     = access_width(instr_id);
        in_valid = in_w != W_NONE;
        in_ok    = is_aligned(in_w, mem_addr[1:0]);
        in_st    = is_store(instr_id);
        in_wstrb = !in_st          ? 4'b0000 :
                   in_w == W_BYTE  ? 4'b0001 << mem_addr[1:0] :
                   in_w == W_HALF  ? (mem_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        in_wdata = !in_st          ? 32'h0 :
                   in_w == W_BYTE  ? {4{store_data[7:0]}} :
                   in_w == W_HALF  ? {2{store_data[15:0]}} : store_data;
    end

    assign timeout = TIMEOUT != 0 && cnt_q >= CW'(TIMEOUT);
    assign ld_op   = !is_store(id_q);

    // next state and registered outputs; completion flags default to a single-cycle pulse
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        lo_d    = lo_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        wb_en_d = 1'b0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        ld_d    = 32'h0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wstrb_d = wstrb_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start && in_valid) begin
                    id_d = instr_id;
                    lo_d = mem_addr[1:0];
                    rd_d = rd_addr;
                    if (!in_ok) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = '0;
                        req_d   = 1'b1;
                        we_d    = in_st;
                        addr_d  = {mem_addr[31:2], 2'b00};
                        wstrb_d = in_wstrb;
                        wdata_d = in_wdata;
                    end
                end
            end
            S_REQ: begin
                if (dmem_ack || timeout) begin
                    state_d = S_FIN;
                    done_d  = 1'b1;
                    err_d   = !dmem_ack;
                    ld_d    = dmem_ack && ld_op ? aligned_data : 32'h0;
                    wb_en_d = dmem_ack && ld_op && rd_q != 5'd0;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = 32'h0;
                    wstrb_d = 4'b0000;
                    wdata_d = 32'h0;
                end else begin
                    cnt_d = &cnt_q ? cnt_q : cnt_q + CW'(1);
                end
            end
            S_FIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            id_q    <= 6'h0;
            lo_q    <= 2'b00;
            rd_q    <= 5'd0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            wb_en_q <= 1'b0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            ld_q    <= 32'h0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wstrb_q <= 4'b0000;
            wdata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            lo_q    <= lo_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            wb_en_q <= wb_en_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            ld_q    <= ld_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wstrb_q <= wstrb_d;
            wdata_q <= wdata_d;
        end
    end

    assign busy       = state_q != S_IDLE;
    assign done       = done_q;
    assign wb_en      = wb_en_q;
    assign wb_rd_addr = rd_q;
    assign load_data  = ld_q;
    assign misaligned = mis_q;
    assign bus_err    = err_q;
    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wstrb = wstrb_q;
    assign dmem_wdata = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks against an arithmetic reference model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  instr_id = 6'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic [4:0]  rd_addr = 5'd0;
    logic        busy, done, wb_en, misaligned, bus_err, dmem_req, dmem_we;
    logic [4:0]  wb_rd_addr;
    logic [31:0] load_data, dmem_addr, dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = 32'h0;

    int tests = 0;
    int fails = 0;
    logic [31:0] last_load;

    always #5 clk = ~clk;

    load_store_unit #(.TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .instr_id   (instr_id),
        .mem_addr   (mem_addr),
        .store_data (store_data),
        .rd_addr    (rd_addr),
        .busy       (busy),
        .done       (done),
        .wb_en      (wb_en),
        .wb_rd_addr (wb_rd_addr),
        .load_data  (load_data),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wstrb (dmem_wstrb),
        .dmem_wdata (dmem_wdata),
        .dmem_ack   (dmem_ack),
        .dmem_rdata (dmem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int size_of(input logic [5:0] id);
        if (id == 6'h14 || id == 6'h17 || id == 6'h19) return 1;
        if (id == 6'h15 || id == 6'h18 || id == 6'h1A) return 2;
        if (id == 6'h16 || id == 6'h1B) return 4;
        return 0;
    endfunction

    // one complete transaction; ack is raised dly cycles after the request is first seen
    task automatic run_op(input logic [5:0] id, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [4:0] rd, input int dly, input logic [31:0] rdata);
        int sz, off;
        logic ld, sgn;
        logic [31:0] v, exp_wd;
        logic [3:0] exp_st;
        sz  = size_of(id);
        off = int'(addr[1:0]);
        ld  = id >= 6'h14 && id <= 6'h18;
        sgn = id == 6'h14 || id == 6'h15;
        @(negedge clk);
        start = 1'b1; instr_id = id; mem_addr = addr; store_data = sd; rd_addr = rd;
        @(negedge clk);
        start = 1'b0; instr_id = 6'($urandom); mem_addr = $urandom; store_data = $urandom; rd_addr = 5'($urandom);
        if (sz == 0) begin
            chk("bad_busy", busy, 0);
            chk("bad_req", dmem_req, 0);
            chk("bad_done", done, 0);
            @(negedge clk);
            chk("bad_done2", done, 0);
        end else if (off % sz != 0) begin
            chk("mis_done", done, 1);
            chk("mis_flag", misaligned, 1);
            chk("mis_req", dmem_req, 0);
            chk("mis_wb", wb_en, 0);
            chk("mis_ld", load_data, 0);
            @(negedge clk);
            chk("mis_busy", busy, 0);
            chk("mis_done2", done, 0);
            chk("mis_req2", dmem_req, 0);
        end else begin
            chk("req", dmem_req, 1);
            chk("busy", busy, 1);
            chk("we", dmem_we, !ld);
            chk("addr", dmem_addr, addr & 32'hFFFF_FFFC);
            if (ld) begin
                chk("wstrb_ld", dmem_wstrb, 0);
            end else begin
                for (int i = 0; i < 4; i++) begin
                    exp_st[i] = i >= off && i < off + sz;
                    exp_wd[8*i +: 8] = 8'(sd >> (8 * (i % sz)));
                end
                chk("wstrb", dmem_wstrb, exp_st);
                chk("wdata", dmem_wdata, exp_wd);
            end
            for (int i = 0; i < dly; i++) begin
                @(negedge clk);
                chk("wait_req", dmem_req, 1);
                chk("wait_done", done, 0);
            end
            dmem_ack = 1'b1; dmem_rdata = rdata;
            @(negedge clk);
            dmem_ack = 1'b0; dmem_rdata = $urandom;
            v = 32'h0;
            if (ld) begin
                v = rdata >> (8 * off);
                if (sz < 4) begin
                    v = v & ((32'd1 << (8 * sz)) - 32'd1);
                    if (sgn && v >= (32'd1 << (8 * sz - 1))) v = v - (32'd1 << (8 * sz));
                end
            end
            chk("done", done, 1);
            chk("bus_err", bus_err, 0);
            chk("misaligned", misaligned, 0);
            chk("load_data", load_data, v);
            chk("wb_en", wb_en, ld && rd != 5'd0);
            chk("wb_rd", wb_rd_addr, rd);
            chk("req_drop", dmem_req, 0);
            last_load = load_data;
            @(negedge clk);
            chk("idle_busy", busy, 0);
            chk("idle_done", done, 0);
        end
    endtask

    initial begin
        int cyc;
        int pick;
        logic [5:0] rid;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wstrb", dmem_wstrb, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_ld", load_data, 0);
        chk("rst_rd", wb_rd_addr, 0);
        chk("rst_flags", {wb_en, misaligned, bus_err}, 0);
        rst = 1'b0;

        run_op(6'h1B, 32'h100, 32'hDEADBEEF, 5'd3, 1, 32'h0);
        run_op(6'h19, 32'h203, 32'h000000A5, 5'd2, 0, 32'h0);
        run_op(6'h14, 32'h203, 32'h0, 5'd5, 0, 32'hA5000000);
        chk("lb_const", last_load, 32'hFFFFFFA5);
        run_op(6'h17, 32'h203, 32'h0, 5'd5, 1, 32'hA5000000);
        chk("lbu_const", last_load, 32'h000000A5);
        run_op(6'h15, 32'h102, 32'h0, 5'd7, 0, 32'h80010000);
        chk("lh_const", last_load, 32'hFFFF8001);
        run_op(6'h15, 32'h102, 32'h0, 5'd0, 2, 32'h80010000);
        run_op(6'h16, 32'h101, 32'h0, 5'd1, 0, 32'h0);

        // ack outside a transaction and an unknown id must both be ignored
        @(negedge clk);
        dmem_ack = 1'b1;
        @(negedge clk);
        dmem_ack = 1'b0;
        chk("idle_ack_done", done, 0);
        chk("idle_ack_busy", busy, 0);
        run_op(6'h05, 32'h100, 32'h0, 5'd1, 0, 32'h0);

        // timeout with a second start issued while busy
        @(negedge clk);
        start = 1'b1; instr_id = 6'h1B; mem_addr = 32'h300; store_data = 32'h12345678;
        @(negedge clk);
        mem_addr = 32'h400;
        chk("to_req", dmem_req, 1);
        chk("to_addr", dmem_addr, 32'h300);
        cyc = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end while (!done && cyc < 20);
        chk("to_cycles", cyc, 5);
        chk("to_err", bus_err, 1);
        chk("to_done", done, 1);
        chk("to_req_drop", dmem_req, 0);
        chk("to_ld", load_data, 0);
        chk("to_wb", wb_en, 0);
        @(negedge clk);
        chk("to_busy", busy, 0);
        chk("to_done2", done, 0);
        repeat (3) begin
            @(negedge clk);
            chk("to_no_extra", dmem_req, 0);
        end

        // ack in the very cycle the timeout expires wins
        run_op(6'h16, 32'h600, 32'h0, 5'd4, 4, 32'h01020304);

        // reset in the middle of a request
        @(negedge clk);
        start = 1'b1; instr_id = 6'h16; mem_addr = 32'h500;
        @(negedge clk);
        start = 1'b0;
        chk("rm_req", dmem_req, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rm_req_low", dmem_req, 0);
        chk("rm_busy", busy, 0);
        chk("rm_done", done, 0);
        @(negedge clk);
        chk("rm_done2", done, 0);
        run_op(6'h16, 32'h504, 32'h0, 5'd9, 0, 32'hCAFEF00D);
        chk("rm_lw_const", last_load, 32'hCAFEF00D);

        for (int n = 0; n < 40; n++) begin
            pick = $urandom_range(0, 9);
            rid = pick < 8 ? 6'(6'h14 + pick) : (pick == 8 ? 6'h00 : 6'h1C);
            run_op(rid, $urandom, $urandom, 5'($urandom), $urandom_range(0, 4), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
